// File: rtl/tipi_pi_bus_4bit.sv
// tipi_pi_bus_4bit
//   Nibble-wide register-access port between the Raspberry Pi and the TIPI
//   CPLD. Every transaction starts with a register-select nibble and is
//   followed by two data nibbles, high nibble first. A read snapshots TD or TC
//   on the select edge and drives the two nibbles back to the Pi. A write
//   gathers two nibbles and updates RD or RC as a whole byte on the last edge.
//
// Ports
//   clk    in     1  Pi-driven bus strobe; all state changes on its rising edge
//   reset  in     1  asynchronous, active-low reset
//   data   inout  4  Pi bus; driven only while read nibbles are being returned
//   TD     in     8  TI data byte readable by the Pi
//   TC     in     8  TI control byte readable by the Pi
//   RD     out    8  Pi data byte, held until the next write or reset
//   RC     out    8  Pi control byte, held until the next write or reset
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released; the next edge samples a select code
// RDH   | driving read_latch[7:4]
// RDL   | driving read_latch[3:0]; the next edge releases the bus
// WRH   | waiting for the high write nibble
// WRL   | waiting for the low write nibble; the next edge updates RD/RC

module tipi_pi_bus_4bit (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [3:0] data,
  input  logic [7:0] TD,
  input  logic [7:0] TC,
  output logic [7:0] RD,
  output logic [7:0] RC
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDH  = 3'd1,
    RDL  = 3'd2,
    WRH  = 3'd3,
    WRL  = 3'd4
  } state_t;

  localparam logic [3:0] SEL_TD = 4'b0000;
  localparam logic [3:0] SEL_TC = 4'b0001;
  localparam logic [3:0] SEL_RD = 4'b0010;
  localparam logic [3:0] SEL_RC = 4'b0011;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] read_latch;
  logic [3:0] staging;
  logic       tgt_rc;
  logic       oe;
  logic [3:0] nib_out;

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    oe        = 1'b0;
    nib_out   = 4'h0;
    case (state)
      IDLE: begin
        case (data)
          SEL_TD, SEL_TC: state_nxt = RDH;
          SEL_RD, SEL_RC: state_nxt = WRH;
          default:        state_nxt = IDLE;
        endcase
      end
      RDH: begin
        oe        = 1'b1;
        nib_out   = read_latch[7:4];
        state_nxt = RDL;
      end
      RDL: begin
        oe        = 1'b1;
        nib_out   = read_latch[3:0];
        state_nxt = IDLE;
      end
      WRH:     state_nxt = WRL;
      WRL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The enable is decoded from the registered state only, so an asynchronous
  // reset releases the bus immediately without needing a clock edge.
  assign data = oe ? nib_out : 4'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers. The read latch is loaded on the select edge so that
  // TD/TC changes during a read cannot tear the returned byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_latch <= 8'h00;
      staging    <= 4'h0;
      tgt_rc     <= 1'b0;
      RD         <= 8'h00;
      RC         <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          case (data)
            SEL_TD:  read_latch <= TD;
            SEL_TC:  read_latch <= TC;
            SEL_RD:  tgt_rc     <= 1'b0;
            SEL_RC:  tgt_rc     <= 1'b1;
            default: ;
          endcase
        end
        WRH: staging <= data;
        WRL: begin
          if (tgt_rc) begin
            RC <= {staging, data};
          end else begin
            RD <= {staging, data};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tipi_pi_bus_4bit.sv
// tb_tipi_pi_bus_4bit
//   Directed bench for tipi_pi_bus_4bit. The bus carries pull-ups (standing in
//   for the Pi side keeper), so a released bus reads 4'hF; the read patterns
//   used here never return 4'hF so a driven nibble is always distinguishable.
//
// Ports: none (top-level bench).

module tb_tipi_pi_bus_4bit;

  logic       clk;
  logic       reset;
  logic [7:0] TD;
  logic [7:0] TC;
  logic [7:0] RD;
  logic [7:0] RC;
  wire  [3:0] data;

  logic       tb_en;
  logic [3:0] tb_drv;

  int total;
  int bad;

  assign data = tb_en ? tb_drv : 4'bz;

  pullup pu0 (data[0]);
  pullup pu1 (data[1]);
  pullup pu2 (data[2]);
  pullup pu3 (data[3]);

  tipi_pi_bus_4bit dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .TD    (TD),
    .TC    (TC),
    .RD    (RD),
    .RC    (RC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One Pi strobe: present a nibble (or leave the bus released) before the
  // rising edge, hold it across the edge, release it, then settle for sampling.
  task automatic bus_edge(input logic en, input logic [3:0] v);
    @(negedge clk);
    tb_en  = en;
    tb_drv = v;
    @(posedge clk);
    #1;
    tb_en = 1'b0;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    tb_en  = 1'b0;
    tb_drv = 4'h0;
    TD     = 8'h00;
    TC     = 8'h00;
    reset  = 1'b0;
    #23;
    chk("rst_bus", {4'h0, data}, 8'h0F);
    chk("rst_rd", RD, 8'h00);
    chk("rst_rc", RC, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Read TD.
    TD = 8'hA5;
    bus_edge(1'b1, 4'b0000);
    chk("td_hi", {4'h0, data}, 8'h0A);
    bus_edge(1'b0, 4'h0);
    chk("td_lo", {4'h0, data}, 8'h05);
    bus_edge(1'b0, 4'h0);
    chk("td_rel", {4'h0, data}, 8'h0F);

    // Read TC; TC changes after the select edge must not leak into the read.
    TC = 8'h5A;
    bus_edge(1'b1, 4'b0001);
    TC = 8'hFF;
    chk("tc_hi", {4'h0, data}, 8'h05);
    bus_edge(1'b0, 4'h0);
    chk("tc_lo", {4'h0, data}, 8'h0A);
    bus_edge(1'b0, 4'h0);
    chk("tc_rel", {4'h0, data}, 8'h0F);

    // Write RD = A5.
    bus_edge(1'b1, 4'b0010);
    bus_edge(1'b1, 4'b1010);
    chk("wrd_early", RD, 8'h00);
    bus_edge(1'b1, 4'b0101);
    chk("wrd_rd", RD, 8'hA5);
    chk("wrd_rc", RC, 8'h00);
    chk("wrd_bus", {4'h0, data}, 8'h0F);

    // Write RC = 5A.
    bus_edge(1'b1, 4'b0011);
    bus_edge(1'b1, 4'b0101);
    bus_edge(1'b1, 4'b1010);
    chk("wrc_rc", RC, 8'h5A);
    chk("wrc_rd", RD, 8'hA5);

    // Unused select code is ignored; a following TD read works normally.
    bus_edge(1'b1, 4'b0111);
    chk("sel7_bus", {4'h0, data}, 8'h0F);
    TD = 8'h3C;
    bus_edge(1'b1, 4'b0000);
    chk("post7_hi", {4'h0, data}, 8'h03);
    bus_edge(1'b0, 4'h0);
    chk("post7_lo", {4'h0, data}, 8'h0C);
    bus_edge(1'b0, 4'h0);
    chk("post7_rel", {4'h0, data}, 8'h0F);

    // Reset in WRL aborts the pending write and clears both registers.
    bus_edge(1'b1, 4'b0010);
    bus_edge(1'b1, 4'b0001);
    reset = 1'b0;
    #1;
    chk("abort_rd", RD, 8'h00);
    chk("abort_rc", RC, 8'h00);
    chk("abort_bus", {4'h0, data}, 8'h0F);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-read releases the bus immediately.
    TD = 8'h96;
    bus_edge(1'b1, 4'b0000);
    chk("rd2_hi", {4'h0, data}, 8'h09);
    #2;
    reset = 1'b0;
    #1;
    chk("rdrst_bus", {4'h0, data}, 8'h0F);
    @(negedge clk);
    reset = 1'b1;
    bus_edge(1'b0, 4'h0);
    chk("rdrst_idle", {4'h0, data}, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
